ifetch_32: RTL

Instruction-fetch stage directly downstream of the PC unit. It consumes the 32-bit fetch address and issues a request/acknowledge read to instruction memory. It holds the returned word in an output register and presents it to decode with a valid/ready handshake. It back-pressures the PC through pc_hold and reports misaligned, bus-error and timeout faults.

---
 rtl/ifetch_32_pkg.sv | 29 ++
 rtl/ifetch_32_timer.sv | 33 +++
 rtl/ifetch_32.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ifetch_32_pkg.sv
// Shared encodings and helpers for the ifetch_32 instruction-fetch stage.
package ifetch_32_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_FULL = 2'b10,
        S_ERR  = 2'b11
    } fetch_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ALIGN   = 2'b01,
        ERR_BUS     = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_code_t;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    // Counter wide enough to hold TIMEOUT itself; a disabled timeout still needs one bit.
    function automatic int timer_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ifetch_32_timer.sv
// Saturating request-wait counter; expired flags the TIMEOUT-th waiting cycle.
module ifetch_timer
    import ifetch_32_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = timer_width(TIMEOUT);
    localparam logic [W-1:0] LAST = W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [W-1:0] SAT  = W'(TIMEOUT);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != SAT)) begin
            count <= count + W'(1);
        end
    end

    // Firing on LAST rather than SAT keeps the request up for exactly TIMEOUT cycles.
    assign expired = (TIMEOUT > 0) && enable && (count == LAST);

endmodule

// File: rtl/ifetch_32.sv
// Instruction-fetch stage: one memory read per instruction, output register with
// valid/ready to decode, PC back-pressure and sticky fault reporting.
module ifetch_32
    import ifetch_32_pkg::*;
#(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_addr,
    output logic        pc_hold,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_err,
    output logic [1:0]  err_code,
    output logic [31:0] err_addr
);

    fetch_state_t state, state_n;
    err_code_t    err_q, err_n;
    logic         mem_req_n, instr_valid_n, drop, drop_n;
    logic [31:0]  mem_addr_n, instruction_n, err_addr_n;
    logic         timer_expired;

    ifetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != S_REQ),
        .enable  (state == S_REQ),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        mem_req_n     = mem_req;
        mem_addr_n    = mem_addr;
        instruction_n = instruction;
        instr_valid_n = instr_valid;
        err_n         = err_q;
        err_addr_n    = err_addr;
        drop_n        = drop;
        case (state)
            S_IDLE: begin
                // A flush here means the PC is loading a new target, so wait for it.
                if (!flush) begin
                    if (!is_aligned(pc_addr)) begin
                        state_n    = S_ERR;
                        err_n      = ERR_ALIGN;
                        err_addr_n = pc_addr;
                    end else begin
                        state_n    = S_REQ;
                        mem_req_n  = 1'b1;
                        mem_addr_n = pc_addr;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    mem_req_n = 1'b0;
                    drop_n    = 1'b0;
                    if (drop || flush) begin
                        state_n = S_IDLE;
                    end else if (mem_err) begin
                        state_n    = S_ERR;
                        err_n      = ERR_BUS;
                        err_addr_n = mem_addr;
                    end else begin
                        state_n       = S_FULL;
                        instruction_n = mem_rdata;
                        instr_valid_n = 1'b1;
                    end
                end else if (timer_expired) begin
                    // A stuck bus is reported even when the fetch was already discarded.
                    mem_req_n  = 1'b0;
                    drop_n     = 1'b0;
                    state_n    = S_ERR;
                    err_n      = ERR_TIMEOUT;
                    err_addr_n = mem_addr;
                end else if (flush) begin
                    drop_n = 1'b1;
                end
            end
            S_FULL: begin
                if (flush) begin
                    instr_valid_n = 1'b0;
                    instruction_n = NOP_WORD;
                    state_n       = S_IDLE;
                end else if (instr_ready) begin
                    instr_valid_n = 1'b0;
                    state_n       = S_IDLE;
                end
            end
            S_ERR: begin
                if (flush) begin
                    err_n      = ERR_NONE;
                    err_addr_n = '0;
                    state_n    = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instruction <= NOP_WORD;
            instr_valid <= 1'b0;
            err_q       <= ERR_NONE;
            err_addr    <= '0;
            drop        <= 1'b0;
        end else begin
            mem_req     <= mem_req_n;
            mem_addr    <= mem_addr_n;
            instruction <= instruction_n;
            instr_valid <= instr_valid_n;
            err_q       <= err_n;
            err_addr    <= err_addr_n;
            drop        <= drop_n;
        end
    end

    // The PC moves only on an accepted instruction or a redirect, never during reset.
    assign pc_hold   = !reset || !((state == S_FULL && instr_ready && !flush) || flush);
    assign fetch_err = (state == S_ERR);
    assign err_code  = err_q;

endmodule
